// File: rtl/cc_jugabilidad_spawner.sv
// Car spawner: turns falling edges of the row-load request into registered
// rows for the background registers, inserting a car every N-th request.
module cc_jugabilidad_spawner #(
  parameter int          RDATAWIDTH = 8,
  parameter int          PW         = 4,
  parameter int          CW         = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  CC_Jugabilidad_CLOCK_50,
  input  logic                  CC_Jugabilidad_RESET_InHigh,
  input  logic                  CC_Jugabilidad_load_InLow,
  input  logic                  CC_Jugabilidad_enable_In,
  input  logic [PW-1:0]         CC_Jugabilidad_period_In,
  input  logic [RDATAWIDTH-1:0] Player_CC_Jugabilidad_data_InBUS,
  output logic [RDATAWIDTH-1:0] Player_CC_Jugabilidad_data_OutBUS,
  output logic                  CC_Jugabilidad_BackregsLoadInLow,
  output logic [CW-1:0]         CC_Jugabilidad_spawnCount_OutBUS,
  output logic                  CC_Jugabilidad_busy_Out
);

  localparam int LW = (RDATAWIDTH > 1) ? $clog2(RDATAWIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_DECIDE = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_SKIP   = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic                  load_q;
  logic [PW-1:0]         req_cnt;
  logic [15:0]           lfsr;
  logic [15:0]           lfsr_nx;
  logic                  req;
  logic [PW-1:0]         neff_m1;
  logic                  spawn;
  logic [LW-1:0]         lane;
  logic [RDATAWIDTH-1:0] onehot;
  logic                  busy_nx;
  logic                  strobe_nx;

  // Request detection, spawn decision, lane one-hot and LFSR step
  always_comb begin
    req     = load_q & ~CC_Jugabilidad_load_InLow;
    neff_m1 = (CC_Jugabilidad_period_In == '0) ? '0
            : CC_Jugabilidad_period_In - 1'b1;
    spawn   = (req_cnt >= neff_m1);
    lane    = lfsr[LW-1:0];
    onehot  = '0;
    for (int i = 0; i < RDATAWIDTH; i++) begin
      onehot[i] = (lane == i[LW-1:0]);
    end
    lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Next-state logic and the registered-output targets derived from it
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_WAIT;
      S_WAIT: begin
        if (req && CC_Jugabilidad_enable_In) begin
          state_nx = S_DECIDE;
        end
      end
      S_DECIDE: state_nx = spawn ? S_SEND : S_SKIP;
      S_SEND:   state_nx = S_HOLD;
      S_SKIP:   state_nx = S_HOLD;
      S_HOLD: begin
        if (CC_Jugabilidad_load_InLow) begin
          state_nx = S_WAIT;
        end
      end
      default:  state_nx = S_IDLE;
    endcase
    busy_nx   = (state_nx == S_DECIDE) || (state_nx == S_SEND) ||
                (state_nx == S_SKIP)   || (state_nx == S_HOLD);
    strobe_nx = !((state_nx == S_SEND) || (state_nx == S_SKIP));
  end

  // State, counters, LFSR and registered outputs
  always_ff @(posedge CC_Jugabilidad_CLOCK_50 or
              posedge CC_Jugabilidad_RESET_InHigh) begin
    if (CC_Jugabilidad_RESET_InHigh) begin
      state                             <= S_IDLE;
      load_q                            <= 1'b1;
      req_cnt                           <= '0;
      lfsr                              <= SEED;
      Player_CC_Jugabilidad_data_OutBUS <= '0;
      CC_Jugabilidad_BackregsLoadInLow  <= 1'b1;
      CC_Jugabilidad_spawnCount_OutBUS  <= '0;
      CC_Jugabilidad_busy_Out           <= 1'b0;
    end else begin
      state                            <= state_nx;
      load_q                           <= CC_Jugabilidad_load_InLow;
      CC_Jugabilidad_busy_Out          <= busy_nx;
      CC_Jugabilidad_BackregsLoadInLow <= strobe_nx;
      if (CC_Jugabilidad_enable_In) begin
        lfsr <= lfsr_nx;
      end
      if (state == S_DECIDE) begin
        if (spawn) begin
          req_cnt                           <= '0;
          Player_CC_Jugabilidad_data_OutBUS <=
            Player_CC_Jugabilidad_data_InBUS | onehot;
          if (CC_Jugabilidad_spawnCount_OutBUS != '1) begin
            CC_Jugabilidad_spawnCount_OutBUS <=
              CC_Jugabilidad_spawnCount_OutBUS + 1'b1;
          end
        end else begin
          req_cnt                           <= req_cnt + 1'b1;
          Player_CC_Jugabilidad_data_OutBUS <=
            Player_CC_Jugabilidad_data_InBUS;
        end
      end
    end
  end

endmodule

// File: tb/tb_cc_jugabilidad_spawner.sv
// Directed plus randomized bench for the car spawner, checked against a
// request-level model (every N-th accepted request inserts a car).
module tb_cc_jugabilidad_spawner;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       load   = 1'b1;
  logic       en     = 1'b0;
  logic [3:0] period = '0;
  logic [7:0] din    = '0;

  logic [7:0] dout;
  logic [7:0] dout2;
  logic       stb;
  logic       stb2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  logic       busy;
  logic       busy2;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_lfsr;
  int          m_mod    = 0;
  int          m_spawns = 0;

  always #5 clk = ~clk;

  cc_jugabilidad_spawner #(
    .RDATAWIDTH(8), .PW(4), .CW(8), .SEED(SEED)
  ) dut (
    .CC_Jugabilidad_CLOCK_50          (clk),
    .CC_Jugabilidad_RESET_InHigh      (rst),
    .CC_Jugabilidad_load_InLow        (load),
    .CC_Jugabilidad_enable_In         (en),
    .CC_Jugabilidad_period_In         (period),
    .Player_CC_Jugabilidad_data_InBUS (din),
    .Player_CC_Jugabilidad_data_OutBUS(dout),
    .CC_Jugabilidad_BackregsLoadInLow (stb),
    .CC_Jugabilidad_spawnCount_OutBUS (cnt),
    .CC_Jugabilidad_busy_Out          (busy)
  );

  cc_jugabilidad_spawner #(
    .RDATAWIDTH(8), .PW(4), .CW(2), .SEED(SEED)
  ) dut2 (
    .CC_Jugabilidad_CLOCK_50          (clk),
    .CC_Jugabilidad_RESET_InHigh      (rst),
    .CC_Jugabilidad_load_InLow        (load),
    .CC_Jugabilidad_enable_In         (en),
    .CC_Jugabilidad_period_In         (period),
    .Player_CC_Jugabilidad_data_InBUS (din),
    .Player_CC_Jugabilidad_data_OutBUS(dout2),
    .CC_Jugabilidad_BackregsLoadInLow (stb2),
    .CC_Jugabilidad_spawnCount_OutBUS (cnt2),
    .CC_Jugabilidad_busy_Out          (busy2)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference LFSR: runs every enabled cycle from SEED
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else if (en) m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b1;
    @(negedge clk);
    m_mod    = 0;
    m_spawns = 0;
    chk("rst_data", dout, 0);
    chk("rst_stb", stb, 1);
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // One request: falling edge, held low for 'hold' cycles
  task automatic req(input int hold, input bit drop);
    bit          acc;
    bit          sp;
    int          neff;
    int          nstb;
    int          at;
    logic [7:0]  seen;
    logic [7:0]  exp_d;
    logic [15:0] lf;
    acc  = en;
    sp   = 1'b0;
    nstb = 0;
    at   = -1;
    seen = '0;
    lf   = '0;
    if (acc) begin
      neff = (period == 0) ? 1 : int'(period);
      sp   = (m_mod >= neff - 1);
      if (sp) begin
        m_mod = 0;
        m_spawns++;
      end else begin
        m_mod++;
      end
    end
    load = 1'b0;
    for (int i = 1; i <= hold + 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        lf = m_lfsr;
        chk("busy_decide", busy, acc);
        if (drop) en = 1'b0;
      end
      if (drop && i == 4) en = 1'b1;
      if (!stb) begin
        nstb++;
        at   = i;
        seen = dout;
      end
      if (i == hold) load = 1'b1;
    end
    chk("strobes", nstb, acc);
    if (acc) begin
      chk("latency", at, 2);
      exp_d = sp ? (din | (8'b1 << lf[2:0])) : din;
      chk("data", seen, exp_d);
    end
    chk("cnt", cnt, imin(m_spawns, 255));
    chk("cnt_sat", cnt2, imin(m_spawns, 3));
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int nstb;
    @(negedge clk);
    @(negedge clk);
    chk("init_data", dout, 0);
    chk("init_stb", stb, 1);
    chk("init_cnt", cnt, 0);
    chk("init_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    en = 1'b1; period = 4'd2; din = 8'h00;
    repeat (4) req(2, 1'b0);
    chk("p2_cnt", cnt, 2);

    period = 4'd0; din = 8'hF0;
    repeat (3) req(1, 1'b0);
    chk("p0_cnt", cnt, 5);

    period = 4'd3; din = 8'h0F;
    req(20, 1'b0);
    req(1, 1'b0);

    en = 1'b0;
    repeat (5) req(2, 1'b0);
    en = 1'b1; period = 4'd1;
    req(6, 1'b1);

    period = 4'd1; din = 8'h81;
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_stb", stb, 0);
    rst = 1'b1;
    @(negedge clk);
    load     = 1'b1;
    m_mod    = 0;
    m_spawns = 0;
    chk("mid_rst_stb", stb, 1);
    chk("mid_rst_data", dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", cnt, 0);
    @(negedge clk);
    rst  = 1'b0;
    nstb = 0;
    repeat (5) begin
      @(negedge clk);
      if (!stb) nstb++;
    end
    chk("no_replay", nstb, 0);
    period = 4'd2; din = 8'h3C;
    req(1, 1'b0);

    do_reset();
    period = 4'd1;
    repeat (6) begin
      din = 8'($urandom);
      req(1, 1'b0);
    end

    for (int k = 0; k < 16; k++) begin
      period = 4'($urandom_range(0, 5));
      din    = 8'($urandom);
      en     = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      req(int'($urandom_range(1, 4)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cc_jugabilidad_spawner.md
CC_JUGABILIDAD_SPAWNER -- requirements
Module: cc_jugabilidad_spawner

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- RDATAWIDTH, 8, row pattern width (lanes)
- PW, 4, period input width
- CW, 8, spawn counter width
- SEED, 16'hACE1, LFSR reset value (nonzero)
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CC_Jugabilidad_CLOCK_50  in  1  system clock
- CC_Jugabilidad_RESET_InHigh  in  1  reset
- CC_Jugabilidad_load_InLow  in  1  row request, active low; falling edge = one request
- CC_Jugabilidad_enable_In  in  1  game running
- CC_Jugabilidad_period_In  in  PW  spawn period N, in requests
- Player_CC_Jugabilidad_data_InBUS  in  RDATAWIDTH  upstream row pattern
- Player_CC_Jugabilidad_data_OutBUS  out  RDATAWIDTH  registered row to background registers
- CC_Jugabilidad_BackregsLoadInLow  out  1  one-cycle active-low load strobe
- CC_Jugabilidad_spawnCount_OutBUS  out  CW  saturating count of spawned cars
- CC_Jugabilidad_busy_Out  out  1  high outside IDLE/WAIT
REQ-003 Reset SHALL be CC_Jugabilidad_RESET_InHigh, asynchronous, active-high; clock SHALL be CC_Jugabilidad_CLOCK_50.

Function
REQ-004 All state SHALL be updated on the rising clock edge only; all outputs SHALL be registered.
REQ-005 The FSM SHALL have states IDLE, WAIT, DECIDE, SEND, SKIP and HOLD.
REQ-006 IDLE SHALL last exactly one cycle after reset release, then go to WAIT.
REQ-007 A request SHALL be a sampled falling edge of load_InLow: previous registered sample 1, current sample 0.
REQ-008 WAIT SHALL go to DECIDE on a request only while enable_In=1; otherwise it SHALL stay in WAIT.
REQ-009 DECIDE SHALL go to SEND if req_cnt == Neff-1, else to SKIP, where Neff = max(period_In, 1), sampled in DECIDE.
REQ-010 In SEND, req_cnt SHALL be cleared to 0; in SKIP, req_cnt SHALL be incremented.
REQ-011 If req_cnt >= Neff-1 in DECIDE (period lowered mid-count), the FSM SHALL go to SEND.
REQ-012 SEND and SKIP SHALL each last one cycle, then go to HOLD.
REQ-013 HOLD SHALL stay until load_InLow samples 1, then go to WAIT. Requests arriving in DECIDE, SEND, SKIP or HOLD SHALL be ignored.
REQ-014 Data_OutBUS and a low strobe SHALL become visible on the same cycle, two cycles after the cycle the request edge is detected.
REQ-015 In SEND, data_OutBUS SHALL be loaded with data_InBUS OR onehot(lane).
- lane = lfsr[clog2(RDATAWIDTH)-1:0].
- If lane >= RDATAWIDTH, no bit SHALL be inserted.
- BackregsLoadInLow SHALL be 0 for that cycle.
REQ-016 In SKIP, data_OutBUS SHALL be loaded with data_InBUS unchanged, and BackregsLoadInLow SHALL be 0 for that cycle.
REQ-017 BackregsLoadInLow SHALL be 1 in every other state; data_OutBUS SHALL hold its value outside SEND and SKIP.
REQ-018 The LFSR SHALL be a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1, advancing every cycle while enable_In=1.
REQ-019 spawnCount SHALL increment by 1 per SEND and saturate at 2^CW-1.
REQ-020 If enable_In drops during DECIDE, SEND, SKIP or HOLD, the current operation SHALL complete; no new request SHALL be accepted until enable_In=1.
REQ-021 busy_Out SHALL be 1 in DECIDE, SEND, SKIP and HOLD, and 0 otherwise.

Reset
REQ-022 Reset SHALL force the following values, whether asserted idle or mid-operation, including during the strobe:
- state IDLE
- data_OutBUS = 0
- BackregsLoadInLow = 1
- spawnCount = 0
- busy_Out = 0
- req_cnt = 0
- lfsr = SEED
- previous load sample = 1
REQ-023 A strobe interrupted by reset SHALL NOT be completed or repeated after reset release.

Verification
REQ-024 period=2, data_In=0x00, 4 clean requests -> 4 one-cycle strobes; outputs 0x00, onehot, 0x00, onehot; spawnCount=2.
REQ-025 period=0, data_In=0xF0, 3 requests -> every request SENDs; each output has popcount 4 or 5 and is a superset of 0xF0; spawnCount=3.
REQ-026 load_InLow held low for 20 cycles after one edge -> exactly one strobe; second edge after release -> second strobe.
REQ-027 enable_In=0, 5 requests -> no strobe, busy stays 0, spawnCount=0; enable rises mid-HOLD -> current op finishes normally.
REQ-028 CW=2, period=1, 6 requests -> spawnCount sequence 1,2,3,3,3,3.
REQ-029 Reset asserted in the SEND cycle -> next cycle strobe=1, data_OutBUS=0x00, state IDLE, req_cnt=0.
